// File: rtl/fpu_sb_pkg.sv
// Shared types for the FPU response scoreboard: status flags, FSM states, NaN detection.
package fpu_sb_pkg;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fp_status_t;

  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_WAIT = 2'd1,
    SB_TOUT = 2'd2
  } sb_state_e;

  localparam int SB_MAX_W = 64;

  // Generic IEEE-style NaN test: exponent all ones and mantissa non-zero.
  function automatic logic fp_is_nan(input logic [SB_MAX_W-1:0] v,
                                     input int exp_w, input int man_w);
    logic exp_ones;
    logic man_nz;
    exp_ones = 1'b1;
    man_nz   = 1'b0;
    for (int i = 0; i < SB_MAX_W; i++) begin
      if (i < man_w)              man_nz   = man_nz | v[i];
      else if (i < man_w + exp_w) exp_ones = exp_ones & v[i];
    end
    return exp_ones & man_nz;
  endfunction

endpackage

// File: rtl/fpu_sb_fifo.sv
// Expected-entry queue: power-of-2 depth, wrap-around pointers, occupancy count.
module fpu_sb_fifo #(
  parameter int W     = 22,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Caller guarantees push-on-full only alongside a pop, and no pop when empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_cnt;

endmodule

// File: rtl/fpu_resp_scoreboard.sv
// In-order scoreboard comparing observed FPU results/flags against queued expectations,
// with a watchdog that flags a stalled DUT.
module fpu_resp_scoreboard
  import fpu_sb_pkg::*;
#(
  parameter int EXP_W     = 5,
  parameter int MAN_W     = 10,
  parameter int DEPTH     = 8,
  parameter int TIMEOUT   = 64,
  parameter int NAN_RELAX = 1,
  localparam int DWIDTH   = 1 + EXP_W + MAN_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     exp_valid_i,
  output logic                     exp_ready_o,
  input  logic [DWIDTH-1:0]        exp_result_i,
  input  logic [4:0]               exp_status_i,
  input  logic                     exp_chk_status_i,
  input  logic                     out_valid_i,
  input  logic                     out_ready_i,
  input  logic [DWIDTH-1:0]        out_result_i,
  input  logic [4:0]               out_status_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   pending_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     mismatch_o,
  output logic                     timeout_o,
  output logic [31:0]              err_cnt_o,
  output logic [31:0]              match_cnt_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = DWIDTH + 6;
  localparam int WW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0]     w_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [EW-1:0]     w_wdata;
  logic [EW-1:0]     w_rdata;
  logic [DWIDTH-1:0] w_head_res;
  fp_status_t        w_head_st;
  logic              w_head_chk;
  logic              w_obs, w_empty, w_full, w_push, w_pop;
  logic              w_res_ok, w_st_ok, w_fail, w_pass;
  logic              w_tout_fire, w_err_inc;
  sb_state_e         r_state, w_state_nxt;
  logic [WW-1:0]     r_wdog, w_wdog_nxt;
  logic              r_mismatch, r_tout;
  logic [31:0]       r_err_cnt, r_match_cnt;

  assign w_obs   = out_valid_i & out_ready_i & ~flush_i;
  assign w_empty = (w_cnt == '0);
  assign w_full  = (w_cnt == CW'(DEPTH));
  assign w_pop   = w_obs & ~w_empty;
  // A push on full is still taken when the head leaves in the same cycle.
  assign w_push  = exp_valid_i & ~flush_i & (~w_full | w_pop);
  assign w_cnt_nxt = flush_i ? '0 : (w_cnt + CW'(w_push) - CW'(w_pop));

  assign w_wdata = {exp_chk_status_i, exp_status_i, exp_result_i};
  assign {w_head_chk, w_head_st, w_head_res} = w_rdata;

  fpu_sb_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_flush (flush_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_count (w_cnt)
  );

  assign w_res_ok = (out_result_i == w_head_res) ||
                    ((NAN_RELAX != 0) &&
                     fp_is_nan(SB_MAX_W'(out_result_i), EXP_W, MAN_W) &&
                     fp_is_nan(SB_MAX_W'(w_head_res), EXP_W, MAN_W));
  assign w_st_ok  = ~w_head_chk | (w_head_st == out_status_i);
  assign w_fail   = w_obs & (w_empty | ~(w_res_ok & w_st_ok));
  assign w_pass   = w_pop & w_res_ok & w_st_ok;

  // Watchdog only runs while results are owed; any observed result restarts it.
  always_comb begin
    w_state_nxt = r_state;
    w_wdog_nxt  = r_wdog;
    w_tout_fire = 1'b0;
    if (flush_i) begin
      w_state_nxt = SB_IDLE;
      w_wdog_nxt  = '0;
    end else begin
      case (r_state)
        SB_IDLE: begin
          if (w_cnt_nxt != '0) begin
            w_state_nxt = SB_WAIT;
            w_wdog_nxt  = '0;
          end
        end
        SB_WAIT: begin
          if (w_cnt_nxt == '0) begin
            w_state_nxt = SB_IDLE;
            w_wdog_nxt  = '0;
          end else if (w_obs) begin
            w_wdog_nxt  = '0;
          end else if (r_wdog == WW'(TIMEOUT - 1)) begin
            w_state_nxt = SB_TOUT;
            w_wdog_nxt  = '0;
            w_tout_fire = 1'b1;
          end else begin
            w_wdog_nxt  = r_wdog + WW'(1);
          end
        end
        SB_TOUT: w_state_nxt = SB_TOUT;
        default: w_state_nxt = SB_IDLE;
      endcase
    end
  end

  assign w_err_inc = w_fail | w_tout_fire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= SB_IDLE;
      r_wdog      <= '0;
      r_tout      <= 1'b0;
      r_mismatch  <= 1'b0;
      r_err_cnt   <= '0;
      r_match_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wdog     <= w_wdog_nxt;
      r_mismatch <= w_fail;
      if (flush_i)          r_tout <= 1'b0;
      else if (w_tout_fire) r_tout <= 1'b1;
      if (w_err_inc && (r_err_cnt != '1))  r_err_cnt   <= r_err_cnt + 32'd1;
      if (w_pass && (r_match_cnt != '1))   r_match_cnt <= r_match_cnt + 32'd1;
    end
  end

  assign exp_ready_o = ~w_full;
  assign pending_o   = w_cnt;
  assign full_o      = w_full;
  assign empty_o     = w_empty;
  assign mismatch_o  = r_mismatch;
  assign timeout_o   = r_tout;
  assign err_cnt_o   = r_err_cnt;
  assign match_cnt_o = r_match_cnt;

endmodule

// File: tb/tb_fpu_resp_scoreboard.sv
// Directed bench for fpu_resp_scoreboard: queue-based reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_fpu_resp_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        exp_valid, exp_chk, out_valid, out_ready, flush;
  logic [15:0] exp_result, out_result;
  logic [4:0]  exp_status, out_status;

  logic        d_ready, d_full, d_empty, d_mis, d_tout;
  logic [3:0]  d_pend;
  logic [31:0] d_err, d_match;
  logic        s_ready, s_full, s_empty, s_mis, s_tout;
  logic [3:0]  s_pend;
  logic [31:0] s_err, s_match;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fpu_resp_scoreboard u_dut (
    .clk_i(clk), .rst_i(rst),
    .exp_valid_i(exp_valid), .exp_ready_o(d_ready),
    .exp_result_i(exp_result), .exp_status_i(exp_status), .exp_chk_status_i(exp_chk),
    .out_valid_i(out_valid), .out_ready_i(out_ready),
    .out_result_i(out_result), .out_status_i(out_status),
    .flush_i(flush),
    .pending_o(d_pend), .full_o(d_full), .empty_o(d_empty),
    .mismatch_o(d_mis), .timeout_o(d_tout),
    .err_cnt_o(d_err), .match_cnt_o(d_match)
  );

  fpu_resp_scoreboard #(.NAN_RELAX(0)) u_strict (
    .clk_i(clk), .rst_i(rst),
    .exp_valid_i(exp_valid), .exp_ready_o(s_ready),
    .exp_result_i(exp_result), .exp_status_i(exp_status), .exp_chk_status_i(exp_chk),
    .out_valid_i(out_valid), .out_ready_i(out_ready),
    .out_result_i(out_result), .out_status_i(out_status),
    .flush_i(flush),
    .pending_o(s_pend), .full_o(s_full), .empty_o(s_empty),
    .mismatch_o(s_mis), .timeout_o(s_tout),
    .err_cnt_o(s_err), .match_cnt_o(s_match)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (index 0: NaN relaxed, 1: strict) ----------------
  typedef struct { logic [15:0] res; logic [4:0] st; bit chk; } ent_t;
  ent_t        m_q[$];
  int unsigned m_err[2], m_match[2];
  bit          m_mis[2];
  bit          m_tout;
  int          m_quiet;

  function automatic bit is_nan16(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
  endfunction

  function automatic bit entry_ok(input ent_t e, input logic [15:0] r,
                                  input logic [4:0] s, input bit relax);
    bit res_ok;
    res_ok = (r == e.res) || (relax && is_nan16(r) && is_nan16(e.res));
    return res_ok && (!e.chk || (s == e.st));
  endfunction

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_q.delete();
      m_err = '{0, 0}; m_match = '{0, 0}; m_mis = '{0, 0};
      m_tout = 0; m_quiet = 0;
    end else if (flush) begin
      m_q.delete();
      m_mis = '{0, 0};
      m_tout = 0; m_quiet = 0;
    end else begin
      bit obs, was_ne, was_full, popped;
      ent_t h;
      obs      = out_valid && out_ready;
      was_ne   = m_q.size() != 0;
      was_full = m_q.size() == 8;
      popped   = 0;
      m_mis    = '{0, 0};
      if (obs) begin
        if (!was_ne) begin
          for (int k = 0; k < 2; k++) begin m_err[k] = sat_inc(m_err[k]); m_mis[k] = 1; end
        end else begin
          h = m_q.pop_front();
          popped = 1;
          for (int k = 0; k < 2; k++) begin
            if (entry_ok(h, out_result, out_status, k == 0)) m_match[k] = sat_inc(m_match[k]);
            else begin m_err[k] = sat_inc(m_err[k]); m_mis[k] = 1; end
          end
        end
      end
      if (exp_valid && (!was_full || popped))
        m_q.push_back('{res: exp_result, st: exp_status, chk: exp_chk});
      if (!m_tout) begin
        if (was_ne && m_q.size() != 0 && !obs) begin
          m_quiet++;
          if (m_quiet == 64) begin
            m_tout = 1;
            for (int k = 0; k < 2; k++) m_err[k] = sat_inc(m_err[k]);
          end
        end else m_quiet = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    chk("pending",     d_pend,   m_q.size());
    chk("full",        d_full,   m_q.size() == 8);
    chk("empty",       d_empty,  m_q.size() == 0);
    chk("exp_ready",   d_ready,  m_q.size() != 8);
    chk("timeout",     d_tout,   m_tout);
    chk("mismatch",    d_mis,    m_mis[0]);
    chk("err_cnt",     d_err,    m_err[0]);
    chk("match_cnt",   d_match,  m_match[0]);
    chk("s_pending",   s_pend,   m_q.size());
    chk("s_timeout",   s_tout,   m_tout);
    chk("s_mismatch",  s_mis,    m_mis[1]);
    chk("s_err_cnt",   s_err,    m_err[1]);
    chk("s_match_cnt", s_match,  m_match[1]);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [15:0] v, input logic [4:0] st, input logic c);
    exp_valid = 1; exp_result = v; exp_status = st; exp_chk = c;
    tick();
    exp_valid = 0;
  endtask

  task automatic observe(input logic [15:0] v, input logic [4:0] st);
    out_valid = 1; out_ready = 1; out_result = v; out_status = st;
    tick();
    out_valid = 0; out_ready = 0;
  endtask

  task automatic reset_pulse();
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  initial begin
    rst = 1; exp_valid = 0; exp_chk = 0; out_valid = 0; out_ready = 0; flush = 0;
    exp_result = '0; out_result = '0; exp_status = '0; out_status = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pending", d_pend, 0);
    chk("rst_empty",   d_empty, 1);
    chk("rst_full",    d_full, 0);
    chk("rst_ready",   d_ready, 1);
    chk("rst_err",     d_err, 0);
    chk("rst_match",   d_match, 0);
    rst = 0;
    tick();

    // in-order matching
    push(16'h3C00, 5'h00, 0);
    push(16'h4000, 5'h00, 0);
    observe(16'h3C00, 5'h00);
    observe(16'h4000, 5'h00);
    chk("basic_match", d_match, 2);
    chk("basic_err",   d_err, 0);
    chk("basic_empty", d_empty, 1);

    // NaN relaxation: relaxed instance matches, strict one flags
    push(16'h7E00, 5'h00, 0);
    observe(16'h7C01, 5'h00);
    chk("nan_relax_match", d_match, 3);
    chk("nan_relax_mis",   d_mis, 0);
    chk("nan_strict_mis",  s_mis, 1);
    chk("nan_strict_err",  s_err, 1);

    // status ignored when chk flag clear
    push(16'h4000, 5'h1F, 0);
    observe(16'h4000, 5'h00);
    chk("nochk_match", d_match, 4);

    // unexpected output while empty
    observe(16'h1234, 5'h00);
    chk("unexp_err",   d_err, 1);
    chk("unexp_mis",   d_mis, 1);
    chk("unexp_s_err", s_err, 2);

    // status checked when chk flag set
    push(16'h3C00, 5'h01, 1);
    observe(16'h3C00, 5'h00);
    chk("status_mis", d_mis, 1);
    chk("status_err", d_err, 2);
    tick();
    chk("mis_pulse_end", d_mis, 0);
    reset_pulse();

    // fill, push+pop on full, pointer wrap
    for (int i = 0; i < 8; i++) push(16'(16'h0100 + i), 5'h00, 0);
    chk("fill_full",    d_full, 1);
    chk("fill_ready",   d_ready, 0);
    chk("fill_pending", d_pend, 8);
    exp_valid = 1; out_valid = 1; out_ready = 1;
    for (int k = 0; k < 17; k++) begin
      exp_result = 16'(16'h0108 + k);
      out_result = 16'(16'h0100 + k);
      out_status = 5'h00; exp_status = 5'h00; exp_chk = 0;
      tick();
      if (k == 0) chk("pushpop_full_pending", d_pend, 8);
    end
    exp_valid = 0; out_valid = 0; out_ready = 0;
    chk("wrap_pending", d_pend, 8);
    chk("wrap_match",   d_match, 17);
    chk("wrap_err",     d_err, 0);
    for (int k = 17; k < 25; k++) observe(16'(16'h0100 + k), 5'h00);
    chk("drain_empty", d_empty, 1);
    chk("drain_match", d_match, 25);
    reset_pulse();

    // watchdog
    push(16'h3C00, 5'h00, 0);
    repeat (63) tick();
    chk("tout_before", d_tout, 0);
    tick();
    chk("tout_set", d_tout, 1);
    chk("tout_err", d_err, 1);
    repeat (5) tick();
    chk("tout_err_once", d_err, 1);
    observe(16'h3C00, 5'h00);
    chk("tout_compare", d_match, 1);
    chk("tout_sticky",  d_tout, 1);
    flush = 1;
    tick();
    flush = 0;
    chk("flush_tout",  d_tout, 0);
    chk("flush_empty", d_empty, 1);
    chk("flush_err",   d_err, 1);

    // flush beats a same-cycle push and pop
    push(16'h4400, 5'h00, 0);
    push(16'h4800, 5'h00, 0);
    flush = 1; exp_valid = 1; exp_result = 16'h4C00;
    out_valid = 1; out_ready = 1; out_result = 16'h4400;
    tick();
    flush = 0; exp_valid = 0; out_valid = 0; out_ready = 0;
    chk("flushwin_pending", d_pend, 0);
    chk("flushwin_match",   d_match, 1);
    chk("flushwin_err",     d_err, 1);

    // asynchronous reset with entries pending
    for (int i = 0; i < 3; i++) push(16'(16'h5000 + i), 5'h00, 0);
    chk("pre_rst_pending", d_pend, 3);
    #2 rst = 1;
    #1;
    chk("arst_pending", d_pend, 0);
    chk("arst_empty",   d_empty, 1);
    chk("arst_full",    d_full, 0);
    chk("arst_mis",     d_mis, 0);
    chk("arst_tout",    d_tout, 0);
    chk("arst_err",     d_err, 0);
    chk("arst_match",   d_match, 0);
    tick();
    rst = 0;
    tick();
    push(16'h3800, 5'h00, 0);
    observe(16'h3800, 5'h00);
    chk("post_rst_match", d_match, 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
